// File: rtl/axis_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_adapter
// Purpose  : AXI-Stream beat packer into core words, plus a core-word FIFO
//            and a serialiser back out to AXI-Stream beats.
// Revision : 1.0 - initial release
// ============================================================================
module axis_stream_adapter #(
    parameter int INP_WIDTH  = 24,
    parameter int OUT_WIDTH  = 12,
    parameter int S_BYTES    = 1,
    parameter int M_BYTES    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          arstn,
    input  logic [8*S_BYTES-1:0]          s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [INP_WIDTH-1:0]          core_inp,
    output logic                          core_inp_valid,
    input  logic                          core_inp_ready,
    input  logic [OUT_WIDTH-1:0]          core_out,
    input  logic                          core_out_valid,
    output logic                          core_out_ready,
    output logic [8*M_BYTES-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SW  = 8 * S_BYTES;
    localparam int IB  = (INP_WIDTH + SW - 1) / SW;
    localparam int IC  = IB * SW;
    localparam int IBW = (IB > 1) ? $clog2(IB) : 1;
    localparam int MW  = 8 * M_BYTES;
    localparam int OB  = (OUT_WIDTH + MW - 1) / MW;
    localparam int OC  = OB * MW;
    localparam int OBW = (OB > 1) ? $clog2(OB) : 1;
    localparam int PAD = OC - OUT_WIDTH;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [0:0] {A_FILL = 1'b0, A_HOLD = 1'b1} asm_state_e;
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} ser_state_e;

    // ------------------------------------------------------------------
    // Assembler
    // ------------------------------------------------------------------
    asm_state_e      asm_q, asm_d;
    logic [IC-1:0]   cont_q, cont_d, cont_next;
    logic [IBW-1:0]  icnt_q, icnt_d;
    logic            ferr_q, ferr_d;
    logic            s_hs;

    generate
        if (IB > 1) begin : g_shift_multi
            assign cont_next = {cont_q[IC-SW-1:0], s_axis_tdata};
        end else begin : g_shift_single
            assign cont_next = s_axis_tdata;
        end
    endgenerate

    assign s_hs = s_axis_tvalid && (asm_q == A_FILL);

    always_comb begin
        asm_d  = asm_q;
        cont_d = cont_q;
        icnt_d = icnt_q;
        ferr_d = 1'b0;
        case (asm_q)
            A_FILL: begin
                if (s_hs) begin
                    cont_d = cont_next;
                    if (icnt_q == IBW'(IB - 1)) begin
                        asm_d  = A_HOLD;
                        icnt_d = '0;
                    end else if (s_axis_tlast) begin
                        // short frame: drop the partial word and resync
                        icnt_d = '0;
                        ferr_d = 1'b1;
                    end else begin
                        icnt_d = icnt_q + 1'b1;
                    end
                end
            end
            A_HOLD: begin
                if (core_inp_ready) asm_d = A_FILL;
            end
            default: asm_d = A_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            asm_q  <= A_FILL;
            cont_q <= '0;
            icnt_q <= '0;
            ferr_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            cont_q <= cont_d;
            icnt_q <= icnt_d;
            ferr_q <= ferr_d;
        end
    end

    assign s_axis_tready  = (asm_q == A_FILL);
    assign core_inp_valid = (asm_q == A_HOLD);
    assign core_inp       = cont_q[IC-1 -: INP_WIDTH];
    assign frame_err      = ferr_q;

    // ------------------------------------------------------------------
    // Output word FIFO
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wp_q, rp_q;
    logic [CW-1:0]        cnt_q;
    logic                 push, pop, fifo_ne;

    assign core_out_ready = (cnt_q < CW'(FIFO_DEPTH));
    assign push           = core_out_valid && core_out_ready;
    assign fifo_ne        = (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= core_out;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign fifo_count = cnt_q;

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    ser_state_e      ser_q, ser_d;
    logic [OC-1:0]   sh_q, sh_d, head_ext;
    logic [OBW-1:0]  ocnt_q, ocnt_d;
    logic            m_hs, last_beat;

    assign head_ext  = OC'(mem_q[rp_q]) << PAD;
    assign m_hs      = (ser_q == S_SEND) && m_axis_tready;
    assign last_beat = (ocnt_q == OBW'(OB - 1));

    always_comb begin
        ser_d  = ser_q;
        sh_d   = sh_q;
        ocnt_d = ocnt_q;
        pop    = 1'b0;
        case (ser_q)
            S_IDLE: begin
                if (fifo_ne) begin
                    pop    = 1'b1;
                    sh_d   = head_ext;
                    ocnt_d = '0;
                    ser_d  = S_SEND;
                end
            end
            S_SEND: begin
                if (m_hs) begin
                    if (last_beat && fifo_ne) begin
                        // back-to-back reload keeps the stream bubble-free
                        pop    = 1'b1;
                        sh_d   = head_ext;
                        ocnt_d = '0;
                    end else if (last_beat) begin
                        sh_d   = sh_q << MW;
                        ocnt_d = '0;
                        ser_d  = S_IDLE;
                    end else begin
                        sh_d   = sh_q << MW;
                        ocnt_d = ocnt_q + 1'b1;
                    end
                end
            end
            default: ser_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ser_q  <= S_IDLE;
            sh_q   <= '0;
            ocnt_q <= '0;
        end else begin
            ser_q  <= ser_d;
            sh_q   <= sh_d;
            ocnt_q <= ocnt_d;
        end
    end

    assign m_axis_tvalid = (ser_q == S_SEND);
    assign m_axis_tdata  = sh_q[OC-1 -: MW];
    assign m_axis_tlast  = (ser_q == S_SEND) && last_beat;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_stream_adapter
// Purpose  : scoreboard bench for axis_stream_adapter (default and wide builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_stream_adapter;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
    logic [23:0] core_inp;
    logic        core_inp_valid, core_inp_ready = 1'b0;
    logic [11:0] core_out = '0;
    logic        core_out_valid = 1'b0, core_out_ready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready = 1'b0;
    logic        frame_err;
    logic [2:0]  fifo_count;

    axis_stream_adapter u_dut (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .core_inp(core_inp), .core_inp_valid(core_inp_valid), .core_inp_ready(core_inp_ready),
        .core_out(core_out), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .frame_err(frame_err), .fifo_count(fifo_count)
    );

    // wide-bus instance
    logic [15:0] wd_s_tdata = '0;
    logic        wd_s_tvalid = 1'b0, wd_s_tlast = 1'b0, wd_s_tready;
    logic [19:0] wd_core_inp;
    logic        wd_core_inp_valid, wd_core_inp_ready = 1'b0;
    logic [11:0] wd_core_out = '0;
    logic        wd_core_out_valid = 1'b0, wd_core_out_ready;
    logic [15:0] wd_m_tdata;
    logic        wd_m_tvalid, wd_m_tlast, wd_m_tready = 1'b0;
    logic        wd_frame_err;
    logic [2:0]  wd_fifo_count;

    axis_stream_adapter #(
        .INP_WIDTH(20), .OUT_WIDTH(12), .S_BYTES(2), .M_BYTES(2), .FIFO_DEPTH(4)
    ) u_wide (
        .clk(clk), .arstn(arstn),
        .s_axis_tdata(wd_s_tdata), .s_axis_tvalid(wd_s_tvalid), .s_axis_tlast(wd_s_tlast),
        .s_axis_tready(wd_s_tready),
        .core_inp(wd_core_inp), .core_inp_valid(wd_core_inp_valid),
        .core_inp_ready(wd_core_inp_ready),
        .core_out(wd_core_out), .core_out_valid(wd_core_out_valid),
        .core_out_ready(wd_core_out_ready),
        .m_axis_tdata(wd_m_tdata), .m_axis_tvalid(wd_m_tvalid), .m_axis_tlast(wd_m_tlast),
        .m_axis_tready(wd_m_tready),
        .frame_err(wd_frame_err), .fifo_count(wd_fifo_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ferr_cnt = 0;
    int n_mbeats = 0;
    logic [23:0] inp_q[$];
    logic [8:0]  out_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (arstn) begin
            if (core_inp_valid && core_inp_ready) begin
                if (inp_q.size() == 0) chk("core_inp_unexpected", 1, 0);
                else chk("core_inp", core_inp, inp_q.pop_front());
            end
            if (m_tvalid && m_tready) begin
                n_mbeats++;
                if (out_q.size() == 0) chk("m_beat_unexpected", {m_tlast, m_tdata}, 9'h1FF);
                else chk("m_beat", {m_tlast, m_tdata}, out_q.pop_front());
            end
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("s_handshake_timeout", 0, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic push_word(input logic [11:0] w);
        logic ok;
        ok = 1'b0;
        core_out_valid = 1'b1;
        core_out       = w;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = core_out_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("push_timeout", 0, 1);
        else begin
            out_q.push_back({1'b0, w[11:4]});
            out_q.push_back({1'b1, w[3:0], 4'h0});
        end
        core_out_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_tready"}, s_tready, 1);
        chk({tag, "_core_out_ready"}, core_out_ready, 1);
        chk({tag, "_core_inp_valid"}, core_inp_valid, 0);
        chk({tag, "_core_inp"}, core_inp, 0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tlast"}, m_tlast, 0);
        chk({tag, "_m_tdata"}, m_tdata, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk_reset_vals("rst");
        arstn = 1'b1;
        tick();

        // assemble
        send_beat(8'hAB, 1'b0);
        send_beat(8'hCD, 1'b0);
        chk("asm_valid_early", core_inp_valid, 0);
        send_beat(8'hEF, 1'b1);
        chk("asm_valid_rise", core_inp_valid, 1);
        chk("asm_tready_hold", s_tready, 0);
        repeat (3) tick();
        chk("asm_hold_valid", core_inp_valid, 1);
        chk("asm_hold_tready", s_tready, 0);
        chk("asm_hold_data", core_inp, 24'hABCDEF);
        inp_q.push_back(24'hABCDEF);
        core_inp_ready = 1'b1;
        tick();
        core_inp_ready = 1'b0;
        chk("asm_release_valid", core_inp_valid, 0);
        chk("asm_release_tready", s_tready, 1);

        // short frame then a full word without tlast
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        chk("short_ferr_pulse", frame_err, 1);
        chk("short_no_word", core_inp_valid, 0);
        tick();
        chk("short_ferr_clear", frame_err, 0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        send_beat(8'h55, 1'b0);
        chk("resync_valid", core_inp_valid, 1);
        inp_q.push_back(24'h334455);
        core_inp_ready = 1'b1;
        tick();
        core_inp_ready = 1'b0;
        chk("ferr_total", ferr_cnt, 1);

        // serialise with latency check
        m_tready = 1'b1;
        push_word(12'hABC);
        chk("ser_lat_n", m_tvalid, 0);
        tick();
        chk("ser_lat_n1", m_tvalid, 1);
        tick();
        tick();
        chk("ser_done_valid", m_tvalid, 0);
        chk("ser_q_empty", out_q.size(), 0);

        // backpressure
        m_tready = 1'b0;
        push_word(12'h111);
        push_word(12'h222);
        push_word(12'h333);
        push_word(12'h444);
        push_word(12'h555);
        chk("bp_count", fifo_count, 4);
        chk("bp_ready", core_out_ready, 0);
        core_out_valid = 1'b1;
        core_out       = 12'h666;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stall_ready", core_out_ready, 0);
            chk("bp_stall_count", fifo_count, 4);
            chk("bp_hold_data", {m_tvalid, m_tlast, m_tdata}, {2'b10, 8'h11});
        end
        core_out_valid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_no_bubble", m_tvalid, 1);
            @(posedge clk);
            #1;
        end
        chk("bp_drained_valid", m_tvalid, 0);
        chk("bp_drained_q", out_q.size(), 0);
        chk("bp_drained_count", fifo_count, 0);

        // reset mid-operation
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        m_tready = 1'b0;
        push_word(12'h777);
        push_word(12'h888);
        push_word(12'h999);
        chk("pre_rst_hold", core_inp_valid, 1);
        chk("pre_rst_count", fifo_count, 2);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        inp_q.delete();
        out_q.delete();
        tick();
        arstn = 1'b1;
        n_mbeats = 0;
        m_tready = 1'b1;
        repeat (10) tick();
        chk("post_rst_beats", n_mbeats, 0);
        chk("post_rst_inp_valid", core_inp_valid, 0);

        // wide-bus instance
        wd_s_tvalid = 1'b1;
        wd_s_tdata  = 16'h1234;
        tick();
        wd_s_tdata  = 16'h5600;
        wd_s_tlast  = 1'b1;
        tick();
        wd_s_tvalid = 1'b0;
        wd_s_tlast  = 1'b0;
        chk("wide_inp_valid", wd_core_inp_valid, 1);
        chk("wide_inp_data", wd_core_inp, 20'h12345);
        wd_core_out_valid = 1'b1;
        wd_core_out       = 12'hABC;
        tick();
        wd_core_out_valid = 1'b0;
        tick();
        chk("wide_m_beat", {wd_m_tvalid, wd_m_tlast, wd_m_tdata}, {2'b11, 16'hABC0});
        wd_m_tready = 1'b1;
        tick();
        chk("wide_m_done", wd_m_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
